cla5_share_ctrl: RTL
====================

// Module: cla5_share_ctrl
// PURPOSE
//  Controller that lets two requesters share one WIDTH-bit carry-lookahead adder.
//  Arbitrates requests round-robin and loads the adder's operand registers.
//  Waits the adder latency, captures the sum/carry, and holds the result until consumed.
//  Sits between the requester ports and the registered CLA datapath; the CLA itself is external.
// PARAMETERS
//  WIDTH    5  operand/sum width in bits
//  ADD_LAT  1  cycles from operand-register load to valid ADD_S/ADD_COUT; legal range 1..15
// PORTS
//  CLK         in   1      single clock; all state updates on rising edge
//  RST_N       in   1      asynchronous, active-low reset
//  REQ0_VALID  in   1      requester 0 has an operation
//  REQ0_A      in   WIDTH  requester 0 operand A
//  REQ0_B      in   WIDTH  requester 0 operand B
//  REQ0_CIN    in   1      requester 0 carry-in
//  REQ0_READY  out  1      requester 0 accepted this cycle when REQ0_VALID&REQ0_READY
//  REQ1_VALID/REQ1_A/REQ1_B/REQ1_CIN/REQ1_READY: same as requester 0
//  ADD_A       out  WIDTH  registered operand A to CLA
//  ADD_B       out  WIDTH  registered operand B to CLA
//  ADD_CIN     out  1      registered carry-in to CLA
//  ADD_S       in   WIDTH  CLA sum
//  ADD_COUT    in   1      CLA carry-out
//  RSP_VALID   out  1      result available
//  RSP_ID      out  1      requester that owns the result
//  RSP_SUM     out  WIDTH  captured sum
//  RSP_COUT    out  1      captured carry-out
//  RSP_READY   in   1      consumer takes result when RSP_VALID&RSP_READY
//  BUSY        out  1      high in EXEC or RESP
// BEHAVIOUR
//  Reset (RST_N=0, async):
//   - state=IDLE; PTR=0 (requester 0 has priority).
//   - All outputs 0: ADD_*, RSP_*, BUSY. READY outputs follow the IDLE rule below.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//  IDLE:
//   - Grant requester PTR if its VALID=1, else the other if its VALID=1.
//   - Only the granted READY is high; READY is combinational from VALID, PTR and state.
//   - Both READY are 0 outside IDLE.
//   - On handshake edge:
//       ADD_A/ADD_B/ADD_CIN <= granted operands
//       RSP_ID <= grant
//       PTR <= ~grant
//       CNT <= ADD_LAT-1
//       -> EXEC
//   - No VALID: remain IDLE, PTR unchanged.
//  EXEC:
//   - Operand regs held stable.
//   - CNT!=0: CNT decrements.
//   - CNT==0: RSP_SUM<=ADD_S, RSP_COUT<=ADD_COUT, -> RESP.
//  RESP:
//   - RSP_VALID=1; RSP_ID/SUM/COUT held stable until RSP_READY.
//   - On RSP_VALID&RSP_READY edge: -> IDLE; RSP_VALID drops next cycle.
//   - RSP_SUM/COUT keep last values.
//  Timing:
//   - RSP_VALID rises exactly ADD_LAT edges after the accept edge.
//   - Minimum spacing between accepts is ADD_LAT+2 cycles.
//   - No new accept in the cycle RSP_READY is taken.
//  Arithmetic: modulo 2^WIDTH.
//   - Carry reported only via RSP_COUT, never widened into RSP_SUM.
//   - Controller does no arithmetic; it passes CLA outputs unmodified.
//  Boundary conditions:
//   - Both VALID in the same IDLE cycle: PTR wins; the other keeps VALID and is served next.
//   - A requester dropping VALID before a handshake is legal; no state change.
//   - RSP_READY held high continuously: each result lasts exactly one cycle.
//   - RSP_READY=0 indefinitely: stall in RESP; both READY stay 0.
//   - Reset mid-EXEC or mid-RESP: in-flight operation discarded; no RSP_VALID pulse.
// TESTING
//  1. Reset, then REQ0 13+25 cin0 (ADD_LAT=1, RSP_READY=1):
//     REQ0_READY=1 in IDLE; RSP_VALID 1 edge later with ID=0, SUM=6, COUT=1.
//  2. REQ0 and REQ1 VALID together from reset: REQ0 served first; REQ1 next.
//     Then a new REQ0+REQ1 pair grants REQ1 first (PTR alternates).
//  3. REQ1 31+0 cin1 with RSP_READY=0 for 5 cycles:
//     RSP_VALID, SUM=0, COUT=1 held; both READY=0; IDLE after RSP_READY=1.
//  4. ADD_LAT=3, REQ0 7+8 cin1:
//     ADD_A=7 / ADD_B=8 stable 3 cycles; RSP_SUM=16 (WIDTH=5), COUT=0, 3 edges after accept.
//  5. Drop RST_N during EXEC: all outputs 0 immediately; PTR=0; no RSP_VALID afterwards.
//  6. Back-to-back REQ0 stream with RSP_READY=1: accepts exactly every ADD_LAT+2 cycles.

Source files
------------

// File: rtl/cla5_share_ctrl.sv
// Shares one external registered CLA between two requesters: round-robin grant in IDLE,
// ADD_LAT-cycle wait in EXEC, result held in RESP until the consumer takes it.
module cla5_share_ctrl #(
  parameter int WIDTH   = 5,
  parameter int ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             req1_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  input  logic             rsp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ADD_LAT - 1);

  state_t     state, state_nxt;
  logic       ptr;
  logic [3:0] cnt;
  logic       gnt_vld;
  logic       gnt_id;
  logic [1:0] req_v;

  assign req_v = {req1_valid, req0_valid};

  // Priority goes to ptr; the other requester only wins when ptr is not asking.
  always_comb begin
    state_nxt  = state;
    gnt_vld    = 1'b0;
    gnt_id     = ptr;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req_v[ptr]) begin
          gnt_vld = 1'b1;
          gnt_id  = ptr;
        end else if (req_v[!ptr]) begin
          gnt_vld = 1'b1;
          gnt_id  = !ptr;
        end
        req0_ready = gnt_vld & ~gnt_id;
        req1_ready = gnt_vld & gnt_id;
        if (gnt_vld) state_nxt = EXEC;
      end
      EXEC: if (cnt == 4'd0) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      cnt      <= 4'd0;
      add_a    <= '0;
      add_b    <= '0;
      add_cin  <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            add_a   <= gnt_id ? req1_a : req0_a;
            add_b   <= gnt_id ? req1_b : req0_b;
            add_cin <= gnt_id ? req1_cin : req0_cin;
            rsp_id  <= gnt_id;
            ptr     <= !gnt_id;
            cnt     <= CNT_INIT;
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_sum  <= add_s;
            rsp_cout <= add_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule
